// File: rtl/mcs_io_master.sv
// Single-outstanding initiator for the MicroBlaze MCS IO bus: takes one command,
// issues a one-cycle strobe, waits (bounded) for io_ready and returns a response.
module mcs_io_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [31:0] io_address,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready
);
    // state  | meaning
    // IDLE   | ready for a command, io_ready ignored
    // STROBE | one-cycle address/read/write strobe, zero-wait completion possible
    // WAIT   | strobes low, bus outputs held, counting toward TIMEOUT
    // RESP   | response presented until rsp_ready
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // WAIT is entered with the counter at 0 one cycle after the strobe, so the
    // last accepted io_ready cycle is seen with the counter at TIMEOUT-1.
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(TLAST);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state;
    logic          wr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wr              <= 1'b0;
            cnt             <= '0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            io_addr_strobe  <= 1'b0;
            io_read_strobe  <= 1'b0;
            io_write_strobe <= 1'b0;
            io_address      <= '0;
            io_byte_enable  <= '0;
            io_write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wr              <= cmd_wr;
                        io_address      <= cmd_addr;
                        io_write_data   <= cmd_wdata;
                        io_byte_enable  <= cmd_be;
                        io_addr_strobe  <= 1'b1;
                        io_read_strobe  <= ~cmd_wr;
                        io_write_strobe <= cmd_wr;
                        cmd_ready       <= 1'b0;
                        busy            <= 1'b1;
                        state           <= STROBE;
                    end
                end
                STROBE: begin
                    io_addr_strobe  <= 1'b0;
                    io_read_strobe  <= 1'b0;
                    io_write_strobe <= 1'b0;
                    cnt             <= '0;
                    if (io_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= wr ? 32'h0 : io_read_data;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (TIMEOUT == 0) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (io_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= wr ? 32'h0 : io_read_data;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mcs_io_master.sv
// Randomized bench for mcs_io_master: each command's response timing and content
// is predicted from the io_ready delay chosen for it, then compared with the DUT.
module tb_mcs_io_master;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [31:0] io_address, io_write_data, io_read_data;
    logic [3:0]  io_byte_enable;
    logic        io_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;

    mcs_io_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // dly: io_ready asserted dly cycles after the strobe cycle (-1 = never).
    // bp: cycles rsp_ready is held low. decoy: keep cmd_valid high while busy.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdata,
                           input int dly, input int bp, input bit decoy);
        int rsp_k, strobe_k, nstb, nrd, nwr, exp_k, bp_stb;
        bit stable, ok, bp_stable, bp_busy;
        logic [31:0] hold_rdata;
        logic hold_err;
        rsp_k = 0; strobe_k = 0; nstb = 0; nrd = 0; nwr = 0; bp_stb = 0;
        stable = 1; bp_stable = 1; bp_busy = 1;

        @(negedge clk);
        check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
        io_read_data = rdata;
        @(posedge clk);
        #1;
        last_acc = cyc;
        cmd_valid = decoy;
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = 4'($urandom);

        for (int k = 1; k <= 40 && rsp_k == 0; k++) begin
            @(negedge clk);
            io_ready = (dly >= 0 && k == dly + 1);
            if (io_addr_strobe) begin nstb++; strobe_k = k; end
            nrd += int'(io_read_strobe);
            nwr += int'(io_write_strobe);
            if (io_address !== addr || io_write_data !== wdata || io_byte_enable !== be) stable = 0;
            if (rsp_valid) rsp_k = k;
        end

        ok = (dly >= 0 && dly <= TO);
        exp_k = ok ? dly + 2 : TO + 2;
        check("strobe_cycle", strobe_k, 32'd1);
        check("strobe_count", nstb, 32'd1);
        check("read_strobes", nrd, wr ? 32'd0 : 32'd1);
        check("write_strobes", nwr, wr ? 32'd1 : 32'd0);
        check("bus_stable", {31'b0, stable}, 32'd1);
        check("rsp_latency", rsp_k, exp_k);
        check("rsp_rdata", rsp_rdata, (ok && !wr) ? rdata : 32'h0);
        check("rsp_err", {31'b0, rsp_err}, ok ? 32'd0 : 32'd1);

        hold_rdata = rsp_rdata;
        hold_err = rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            io_ready = 1'($urandom);
            if (!rsp_valid || rsp_rdata !== hold_rdata || rsp_err !== hold_err) bp_stable = 0;
            if (io_addr_strobe || io_read_strobe || io_write_strobe) bp_stb++;
            if (cmd_ready || !busy) bp_busy = 0;
        end
        check("bp_rsp_stable", {31'b0, bp_stable}, 32'd1);
        check("bp_no_strobe", bp_stb, 32'd0);
        check("bp_cmd_blocked", {31'b0, bp_busy}, 32'd1);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        io_ready = 1'b0;
    endtask

    initial begin
        int prev;
        bit seen;
        reset = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_be = 0;
        rsp_ready = 0; io_read_data = 0; io_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rsp", {29'b0, rsp_valid, rsp_err, 1'b0}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_strobes", {29'b0, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'd0);
        check("rst_addr", io_address, 32'h0);
        check("rst_wdata", io_write_data, 32'h0);
        check("rst_be", {28'b0, io_byte_enable}, 32'd0);

        // zero-wait read, wait-state write, timeout and last-cycle ready
        run_txn(1'b0, 32'hC000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
        run_txn(1'b1, 32'hC000_0204, 32'h0000_00A5, 4'h1, 32'h1234_5678, 3, 0, 0);
        run_txn(1'b0, 32'hC000_0300, 32'h0, 4'hF, 32'hCAFE_F00D, -1, 0, 0);
        run_txn(1'b0, 32'hC000_0304, 32'h0, 4'hF, 32'hCAFE_F00D, TO, 0, 0);
        run_txn(1'b0, 32'hC000_0308, 32'h0, 4'hF, 32'h0BAD_CAFE, TO + 1, 0, 0);
        // backpressure with a pending command
        run_txn(1'b0, 32'hC000_0400, 32'h0, 4'h3, 32'h5555_AAAA, 1, 10, 1);

        // io_ready in IDLE is ignored
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            io_ready = 1'b1;
            if (busy || rsp_valid || io_addr_strobe) seen = 1;
        end
        @(negedge clk);
        io_ready = 1'b0;
        if (busy || rsp_valid || io_addr_strobe) seen = 1;
        check("idle_ready_ignored", {31'b0, seen}, 32'd0);

        // three back-to-back zero-wait commands
        run_txn(1'b0, 32'hC000_0500, 32'h0, 4'hF, 32'h1111_1111, 0, 0, 0);
        prev = last_acc;
        run_txn(1'b1, 32'hC000_0504, 32'h2222_2222, 4'hF, 32'h0, 0, 0, 0);
        check("b2b_spacing_1", last_acc - prev, 32'd3);
        prev = last_acc;
        run_txn(1'b0, 32'hC000_0508, 32'h0, 4'hC, 32'h3333_3333, 0, 0, 0);
        check("b2b_spacing_2", last_acc - prev, 32'd3);

        // reset during WAIT discards the transaction
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'hC000_0600; cmd_be = 4'hF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_strobes", {29'b0, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'd0);
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1;
        end
        check("midrst_no_rsp", {31'b0, seen}, 32'd0);
        run_txn(1'b0, 32'hC000_0604, 32'h0, 4'hF, 32'h600D_600D, 2, 1, 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int d;
            d = ($urandom_range(0, 9) == 9) ? -1 : int'($urandom_range(0, TO + 2));
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
                    d, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mcs_io_master.md
Name: mcs_io_master

Overview:
- Initiator for the MicroBlaze MCS IO bus. It drives the same strobe/address/data/ready protocol that the MCS CPU presents to chu_mcs_bridge.
- Lets a hardware agent (debug UART command decoder, DMA sequencer, or testbench driver) issue single 32-bit reads and writes into the bridge and fpro MMIO space without the CPU.
- Commands enter on a valid/ready interface. Responses leave on a valid/ready interface.

Parameters:
- TIMEOUT, 255: max cycles to wait for io_ready after the strobe cycle. 0 means io_ready must arrive in the strobe cycle itself.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address, passed through unmodified (bridge base included by the caller)
- cmd_wdata  in  32  write data
- cmd_be  in  4  byte enables
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and for timeouts
- rsp_err  out  1  1 = timeout (no io_ready received)
- busy  out  1  high in any state except IDLE
- io_addr_strobe  out  1  one-cycle transaction strobe
- io_read_strobe  out  1  one-cycle read strobe
- io_write_strobe  out  1  one-cycle write strobe
- io_address  out  32  transaction address
- io_byte_enable  out  4  byte enables
- io_write_data  out  32  write data
- io_read_data  in  32  read data, sampled in the io_ready cycle
- io_ready  in  1  transaction complete

Behaviour:
- Reset values:
  - State is IDLE.
  - cmd_ready=1, busy=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All io strobes are 0.
  - io_address, io_byte_enable and io_write_data are 0.
- FSM has four states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch wr/addr/wdata/be into the io_* output registers and go to STROBE.
  - io_ready in IDLE is ignored.
- STROBE (exactly one cycle):
  - io_addr_strobe=1.
  - io_write_strobe=cmd_wr; io_read_strobe=!cmd_wr.
  - io_address, io_byte_enable and io_write_data are valid.
  - If io_ready=1 in this cycle, capture the response and go to RESP. This supports a zero-wait responder with io_ready tied high.
  - Otherwise clear the wait counter and go to WAIT. If TIMEOUT=0, go directly to RESP with err=1 instead.
- WAIT:
  - All strobes are 0. io_address, io_byte_enable and io_write_data are held stable.
  - The counter increments each cycle.
  - If io_ready=1, capture and go to RESP. This applies even in the final allowed cycle.
  - If the counter reaches TIMEOUT with no io_ready, go to RESP with rsp_err=1.
  - Timing: strobe at cycle S; io_ready accepted at cycles S..S+TIMEOUT; on timeout, rsp_valid rises at S+TIMEOUT+1.
- Capture rules:
  - Read: rsp_rdata=io_read_data, rsp_err=0.
  - Write: rsp_rdata=0, rsp_err=0.
  - Timeout: rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE. cmd_ready rises the next cycle, so there is no cmd accept in the same cycle as rsp handshake.
- Latency: with a zero-wait responder, cmd accept at T, strobe at T+1, rsp_valid at T+2. Back-to-back throughput is one transaction per 3 cycles when rsp_ready is held high.
- One outstanding transaction only. cmd_ready=0 in STROBE, WAIT and RESP.
- io_ready arriving after the response is captured, or a second pulse in the same transaction, is ignored.
- Reset mid-transaction:
  - Next cycle is IDLE with all strobes 0 and rsp_valid=0.
  - The pending response is discarded and no retry is made.
- Counter width is clog2(TIMEOUT+1), minimum 1. The counter saturates and never wraps.

Test Plan:
1. Zero-wait read: io_ready tied 1, io_read_data=32'hDEAD_BEEF; read cmd at addr 32'hC000_0010, be=4'hF → one-cycle io_addr_strobe+io_read_strobe at T+1; rsp_valid at T+2 with rdata=DEAD_BEEF, err=0.
2. Wait-state write: write 32'h0000_00A5 to 32'hC000_0204, be=4'h1; io_ready asserted 3 cycles after strobe → io_address and io_write_data stable for all 4 cycles; single write strobe; rsp_valid the cycle after io_ready with rdata=0, err=0.
3. Timeout: TIMEOUT=4, io_ready never asserted → rsp_valid exactly 5 cycles after the strobe cycle, err=1, rdata=0. Repeat with io_ready at S+4 → err=0.
4. Response backpressure: rsp_ready held low for 10 cycles → rsp_valid, rsp_rdata and rsp_err stable; cmd_ready=0 and no new strobe despite cmd_valid=1; next command accepted the cycle after rsp_ready falls back to IDLE.
5. Spurious/late ready: io_ready pulses in IDLE and again during RESP → no state change and only one response per command. Three back-to-back commands with zero-wait → three responses at 3-cycle spacing in order.
6. Reset mid-WAIT: assert reset during WAIT → next cycle busy=0, all strobes 0, rsp_valid=0; a subsequent read completes normally.
